rx_shift_ctrl: RTL
==================

// Module: rx_shift_ctrl
// PURPOSE
//  Bit-timing and framing controller for the serial receive path. Watches
//  the serial line, detects start bit, issues one shift_strobe per data bit
//  at mid-bit to the downstream shift register, validates the stop bit,
//  then pulses load_buffer and runs a data_ready/data_read handshake with
//  overrun and framing error flags.
// PARAMETERS
//  CLKS_PER_BIT   10  clk cycles per serial bit period (>=4, even)
//  NUM_DATA_BITS   8  data bits per frame, i.e. strobes per frame (1..32)
// PORTS
//  clk            in   1  system clock, all state on rising edge
//  n_rst          in   1  reset, asynchronous, active-low
//  serial_in      in   1  raw async serial line, idle high
//  data_read      in   1  consumer has taken buffered data (1-cycle pulse)
//  shift_strobe   out  1  shift enable to serial-to-parallel register
//  load_buffer    out  1  1-cycle pulse: copy shift register to rx buffer
//  data_ready     out  1  rx buffer holds unread data
//  framing_error  out  1  last frame had a low stop bit
//  overrun_error  out  1  new frame loaded while data_ready still set
//  rx_busy        out  1  frame in progress (state != IDLE)
// BEHAVIOUR
//  Reset: sync flops=1, state=IDLE, timer=0, bit_cnt=0; all outputs 0.
//  Input sync: 2-flop synchronizer plus one history flop (s_prev); all
//   decisions use synchronized s only. Start edge = s_prev==1 && s==0.
//  Timer: clog2(CLKS_PER_BIT) bits, cleared on every state entry.
//   bit_cnt: clog2(NUM_DATA_BITS+1) bits.
//  States (one-hot or binary, implementer's choice):
//   IDLE: on start edge -> START_CHK; framing_error cleared same edge.
//   START_CHK: count to CLKS_PER_BIT/2-1; then s==0 -> SHIFT (bit_cnt=0),
//    s==1 -> IDLE (glitch rejected, no strobe, no flags).
//   SHIFT: count to CLKS_PER_BIT-1; at terminal count shift_strobe=1 for
//    exactly that cycle, bit_cnt++, timer wraps to 0. When strobe makes
//    bit_cnt==NUM_DATA_BITS -> STOP_CHK.
//   STOP_CHK: count to CLKS_PER_BIT-1, sample s: 1 -> LOAD;
//    0 -> framing_error<=1, -> WAIT_HIGH (no load, data_ready untouched).
//   LOAD: load_buffer=1 for this single cycle; data_ready<=1; if data_ready
//    already 1 and data_read low this cycle, overrun_error<=1. -> IDLE.
//   WAIT_HIGH: stay until s==1, then -> IDLE (no retrigger on stuck-low).
//  shift_strobe/load_buffer decode registered state+timer only; no
//   combinational path from any input to any output.
//  Strobe timing: first strobe 1.5 bit periods after start edge seen on s,
//   then every CLKS_PER_BIT cycles; exactly NUM_DATA_BITS per frame.
//  data_read: clears data_ready and overrun_error next cycle. data_read in
//   same cycle as LOAD: data_ready stays 1, overrun not set.
//  framing_error holds until next accepted start edge (not data_read).
//  serial_in activity outside IDLE/WAIT_HIGH ignored except for sampling.
//  n_rst mid-frame: immediate return to reset values, partial frame dropped,
//   no load_buffer; needs a fresh falling edge after release.
//  rx_busy = (state != IDLE).
// TESTING (CLKS_PER_BIT=10, NUM_DATA_BITS=8)
//  Good frame 0xA5 LSB-first, stop=1 -> 8 strobes 10 clk apart, first 15
//   clk after s falls; 1 load_buffer pulse; data_ready=1, errors=0.
//  Low pulse 3 clk on idle line -> START_CHK then IDLE; no strobe, rx_busy
//   high <=6 clk, no flags.
//  Frame with stop=0 -> 8 strobes, no load_buffer, framing_error=1, holds
//   through line-low; next good frame clears it at its start edge.
//  Two good frames, no data_read -> 2nd load sets overrun_error=1; one
//   data_read pulse -> data_ready=0, overrun_error=0 next cycle.
//  data_read coincident with LOAD of 2nd frame -> data_ready=1, overrun=0.
//  n_rst low after 4th strobe -> outputs 0, state IDLE; line held low at
//   release -> no activity until a new 1->0 edge.

Source files
------------

// File: rtl/rx_shift_ctrl.sv
// rx_shift_ctrl: bit-timing and framing controller for the serial receive path.
// Finds the start bit, strobes the downstream shift register once per data bit
// at mid-bit, checks the stop bit, then loads the rx buffer and tracks the
// data_ready / data_read handshake along with framing and overrun errors.
module rx_shift_ctrl #(
    parameter int CLKS_PER_BIT  = 10,
    parameter int NUM_DATA_BITS = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic serial_in,
    input  logic data_read,
    output logic shift_strobe,
    output logic load_buffer,
    output logic data_ready,
    output logic framing_error,
    output logic overrun_error,
    output logic rx_busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(NUM_DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(NUM_DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        SHIFT,
        STOP_CHK,
        LOAD,
        WAIT_HIGH
    } state_t;

    state_t        state, next_state;
    logic [TW-1:0] timer, next_timer;
    logic [BW-1:0] bit_cnt, next_bit_cnt;
    logic          sync1, s, s_prev;
    logic [2:0]    sync_valid;
    logic          start_edge;
    logic          set_framing;

    // Two-flop synchronizer plus history flop; sync_valid marks which stages
    // hold real line samples rather than the idle-high reset value.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1      <= 1'b1;
            s          <= 1'b1;
            s_prev     <= 1'b1;
            sync_valid <= '0;
        end else begin
            sync1      <= serial_in;
            s          <= sync1;
            s_prev     <= s;
            sync_valid <= {sync_valid[1:0], 1'b1};
        end
    end

    // A line already low at reset release must not look like a falling edge,
    // so edges only count once s_prev holds a genuine sample.
    assign start_edge = sync_valid[2] & s_prev & ~s;

    // State, bit timer and data bit counter registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= next_state;
            timer   <= next_timer;
            bit_cnt <= next_bit_cnt;
        end
    end

    // Next-state logic; the timer restarts from zero on every state entry.
    always_comb begin
        next_state   = state;
        next_timer   = timer + 1'b1;
        next_bit_cnt = bit_cnt;
        set_framing  = 1'b0;
        case (state)
            IDLE: begin
                next_timer = '0;
                if (start_edge) begin
                    next_state = START_CHK;
                end
            end
            START_CHK: begin
                if (timer == HALF_LAST) begin
                    next_timer   = '0;
                    next_bit_cnt = '0;
                    next_state   = s ? IDLE : SHIFT;
                end
            end
            SHIFT: begin
                if (timer == BIT_LAST) begin
                    next_timer   = '0;
                    next_bit_cnt = bit_cnt + 1'b1;
                    if (bit_cnt == BITS_LAST) begin
                        next_state = STOP_CHK;
                    end
                end
            end
            STOP_CHK: begin
                if (timer == BIT_LAST) begin
                    next_timer = '0;
                    if (s) begin
                        next_state = LOAD;
                    end else begin
                        set_framing = 1'b1;
                        next_state  = WAIT_HIGH;
                    end
                end
            end
            LOAD: begin
                next_timer = '0;
                next_state = IDLE;
            end
            WAIT_HIGH: begin
                next_timer = '0;
                if (s) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_timer = '0;
                next_state = IDLE;
            end
        endcase
    end

    assign shift_strobe = (state == SHIFT) && (timer == BIT_LAST);
    assign load_buffer  = (state == LOAD);
    assign rx_busy      = (state != IDLE);

    // Status flags: framing error lives until the next start edge, while the
    // buffer handshake is driven by LOAD and by the consumer's data_read.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            if (state == IDLE && start_edge) begin
                framing_error <= 1'b0;
            end else if (set_framing) begin
                framing_error <= 1'b1;
            end

            if (state == LOAD) begin
                data_ready <= 1'b1;
                if (data_ready && !data_read) begin
                    overrun_error <= 1'b1;
                end else if (data_read) begin
                    overrun_error <= 1'b0;
                end
            end else if (data_read) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end
        end
    end

endmodule
